// File: rtl/md_pkg.sv
// ---------------------------------------------------------------------------
// md_pkg -- shared constants and types for the md_sequencer multi-cycle
// multiply / multiply-accumulate / divide unit.
//   WIDTH       operand width (the datapath is built for 32 only)
//   ITER_CNT_W  width of the RUN iteration counter (32 iterations, wraps)
//   op_e        operation encodings
//   state_e     sequencer states
//   mag33()     operand magnitude, 33 bits so signed -2^31 maps to 2^31
// ---------------------------------------------------------------------------
package md_pkg;

  localparam int WIDTH      = 32;
  localparam int ITER_CNT_W = 5;

  typedef enum logic [1:0] {
    OP_MUL = 2'b00,
    OP_MLA = 2'b01,
    OP_DIV = 2'b10,
    OP_RSV = 2'b11   // decoded as MUL
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX,
    S_DONE
  } state_e;

  // Sign-extend to 33 bits when signed, then take the absolute value.
  function automatic logic [32:0] mag33(input logic [31:0] v, input logic is_signed);
    logic [32:0] ext;
    ext = {is_signed & v[31], v};
    return ext[32] ? (~ext + 33'd1) : ext;
  endfunction

endpackage

// File: rtl/md_iter_step.sv
// ---------------------------------------------------------------------------
// md_iter_step -- one combinational iteration of the sequencer's RUN loop:
// a 33-bit add (shift-add multiply) or subtract (restoring divide).
//   i_x, i_y  33-bit operands
//   i_sub     1 = i_x - i_y, 0 = i_x + i_y
//   o_res     34-bit result; bit 33 is the carry (add) or borrow (subtract)
// ---------------------------------------------------------------------------
module md_iter_step (
  input  logic [32:0] i_x,
  input  logic [32:0] i_y,
  input  logic        i_sub,
  output logic [33:0] o_res
);

  assign o_res = i_sub ? ({1'b0, i_x} - {1'b0, i_y})
                       : ({1'b0, i_x} + {1'b0, i_y});

endmodule

// File: rtl/md_sequencer.sv
// ---------------------------------------------------------------------------
// md_sequencer -- iterative 32x32 multiply, multiply-accumulate and divide.
// IDLE -> PREP -> RUN (32 cycles) -> FIX -> DONE -> IDLE; done is seen
// 35 cycles after the start-accept edge (3 cycles for skipped divides).
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   start             request, sampled only in IDLE
//   op                00 MUL, 01 MLA, 10 DIV, 11 MUL
//   unsigned_op       1 unsigned, 0 two's complement
//   long_op           MLA accumulator {c,d} when 1, {0,c} when 0
//   a, b, c, d        operands (a/b multiplicands or dividend/divisor)
//   busy, done        in-flight flag, one-cycle completion pulse
//   result, result2   product low/high, or quotient/remainder
//   div_by_zero       set by a divide that produced no quotient
// Build option: define MD_DIV_EN to include the divide datapath; without it
// every DIV finishes early with result=0, result2=0, div_by_zero=1.
// ---------------------------------------------------------------------------
module md_sequencer #(
  parameter int WIDTH = md_pkg::WIDTH   // only 32 is supported
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             unsigned_op,
  input  logic             long_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result2,
  output logic             div_by_zero
);

  import md_pkg::*;

  state_e                r_state, w_next;
  op_e                   r_op;
  logic                  r_uns, r_long;
  logic [31:0]           r_a, r_b, r_c, r_d;
  logic [ITER_CNT_W-1:0] r_iter;
  logic [32:0]           r_hi;     // partial product high / partial remainder
  logic [31:0]           r_lo;     // multiplier shifting out / quotient shifting in
  logic [32:0]           r_mag;    // multiplicand or divisor magnitude
  logic                  r_neg_q;  // product or quotient must be negated
`ifdef MD_DIV_EN
  logic                  r_neg_r;  // remainder takes the dividend's sign
`endif
  logic [31:0]           r_result, r_result2;
  logic                  r_dbz;

  logic                  w_skip;
  logic [32:0]           w_step_x, w_step_y;
  logic                  w_step_sub;
  logic [33:0]           w_step;
  logic [63:0]           w_prod, w_prod_s, w_acc, w_fix;
  logic                  w_fix_dbz;

  assign busy        = (r_state == S_PREP) || (r_state == S_RUN) || (r_state == S_FIX);
  assign done        = (r_state == S_DONE);
  assign result      = r_result;
  assign result2     = r_result2;
  assign div_by_zero = r_dbz;

  // A divide with nothing to iterate jumps straight from PREP to FIX.
`ifdef MD_DIV_EN
  assign w_skip = (r_op == OP_DIV) && (r_b == '0);
`else
  assign w_skip = (r_op == OP_DIV);
`endif

  // NOTE: state and datapath registers use non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every signal written in an always_comb block gets a default first,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_PREP;
      S_PREP:  w_next = w_skip ? S_FIX : S_RUN;
      S_RUN:   if (r_iter == '1) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operands of the single shared add/subtract step.
  always_comb begin
    w_step_x   = r_hi;
    w_step_y   = r_lo[0] ? r_mag : '0;
    w_step_sub = 1'b0;
`ifdef MD_DIV_EN
    if (r_op == OP_DIV) begin
      w_step_x   = {r_hi[31:0], r_lo[31]};
      w_step_y   = r_mag;
      w_step_sub = 1'b1;
    end
`endif
  end

  md_iter_step u_step (
    .i_x   (w_step_x),
    .i_y   (w_step_y),
    .i_sub (w_step_sub),
    .o_res (w_step)
  );

  // FIX-stage result: {result2, result}.
  assign w_prod = {r_hi[31:0], r_lo};

  always_comb begin
    w_prod_s  = r_neg_q ? (~w_prod + 64'd1) : w_prod;
    w_acc     = r_long ? {r_c, r_d} : {32'h0, r_c};
    w_fix     = (r_op == OP_MLA) ? (w_prod_s + w_acc) : w_prod_s;
    w_fix_dbz = 1'b0;
    if (r_op == OP_DIV) begin
`ifdef MD_DIV_EN
      if (r_b == '0) begin
        w_fix     = {r_a, 32'h0};
        w_fix_dbz = 1'b1;
      end else begin
        w_fix[31:0]  = r_neg_q ? -r_lo : r_lo;
        w_fix[63:32] = r_neg_r ? -r_hi[31:0] : r_hi[31:0];
      end
`else
      w_fix     = '0;
      w_fix_dbz = 1'b1;
`endif
    end
  end

  // NOTE: the operand latches are reset along with the visible state; they are
  // few and it keeps post-reset behaviour fully deterministic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op      <= OP_MUL;
      r_uns     <= 1'b0;
      r_long    <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_c       <= '0;
      r_d       <= '0;
      r_iter    <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_mag     <= '0;
      r_neg_q   <= 1'b0;
`ifdef MD_DIV_EN
      r_neg_r   <= 1'b0;
`endif
      r_result  <= '0;
      r_result2 <= '0;
      r_dbz     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op   <= op_e'(op);
            r_uns  <= unsigned_op;
            r_long <= long_op;
            r_a    <= a;
            r_b    <= b;
            r_c    <= c;
            r_d    <= d;
          end
        end
        S_PREP: begin
          r_iter  <= '0;
          r_hi    <= '0;
          r_neg_q <= ~r_uns & (r_a[31] ^ r_b[31]);
          if (r_op == OP_DIV) begin
            r_lo  <= 32'(mag33(r_a, ~r_uns));
            r_mag <= mag33(r_b, ~r_uns);
          end else begin
            r_lo  <= 32'(mag33(r_b, ~r_uns));
            r_mag <= mag33(r_a, ~r_uns);
          end
`ifdef MD_DIV_EN
          r_neg_r <= ~r_uns & r_a[31];
`endif
        end
        S_RUN: begin
          r_iter <= r_iter + 1'b1;
`ifdef MD_DIV_EN
          if (r_op == OP_DIV) begin
            // Restoring divide: keep the difference only if it did not borrow.
            r_hi <= w_step[33] ? w_step_x : w_step[32:0];
            r_lo <= {r_lo[30:0], ~w_step[33]};
          end else begin
            r_hi <= w_step[33:1];
            r_lo <= {w_step[0], r_lo[31:1]};
          end
`else
          r_hi <= w_step[33:1];
          r_lo <= {w_step[0], r_lo[31:1]};
`endif
        end
        S_FIX: begin
          r_result  <= w_fix[31:0];
          r_result2 <= w_fix[63:32];
          r_dbz     <= w_fix_dbz;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// ---------------------------------------------------------------------------
// tb_md_sequencer -- self-checking bench for md_sequencer. Expected results
// come from a behavioural model using plain 64-bit arithmetic. Honours the
// MD_DIV_EN build option the same way as the design.
// ---------------------------------------------------------------------------
module tb_md_sequencer;

  typedef struct {
    logic [31:0] r;
    logic [31:0] r2;
    logic        dbz;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic        unsigned_op = 1'b0;
  logic        long_op = 1'b0;
  logic [31:0] a = '0, b = '0, c = '0, d = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] result, result2;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] prev_r = '0, prev_r2 = '0;
  logic        prev_dbz = 1'b0;

  always #5 clk = ~clk;

  md_sequencer #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .unsigned_op (unsigned_op),
    .long_op     (long_op),
    .a           (a),
    .b           (b),
    .c           (c),
    .d           (d),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .result2     (result2),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic u, input logic l,
                                 input logic [31:0] xa, xb, xc, xd);
    exp_t        e;
    logic [63:0] p;
    longint      sa, sb, q, rm;
    e.dbz = 1'b0;
    e.lat = 35;
    if (o == 2'b10) begin
`ifdef MD_DIV_EN
      if (xb == 0) begin
        e.r = 0; e.r2 = xa; e.dbz = 1'b1; e.lat = 3;
      end else if (u) begin
        e.r = xa / xb; e.r2 = xa % xb;
      end else begin
        sa = longint'($signed(xa));
        sb = longint'($signed(xb));
        q  = sa / sb;
        rm = sa % sb;
        e.r = q[31:0]; e.r2 = rm[31:0];
      end
`else
      e.r = 0; e.r2 = 0; e.dbz = 1'b1; e.lat = 3;
`endif
    end else begin
      if (u) p = {32'h0, xa} * {32'h0, xb};
      else   p = longint'($signed(xa)) * longint'($signed(xb));
      if (o == 2'b01) p = p + (l ? {xc, xd} : {32'h0, xc});
      e.r = p[31:0]; e.r2 = p[63:32];
    end
    return e;
  endfunction

  // Called at a negedge; returns at the negedge where done was observed.
  task automatic run_op(input string tag, input logic [1:0] o, input logic u, input logic l,
                        input logic [31:0] xa, xb, xc, xd, input bit noise);
    exp_t e;
    int   cyc;
    e = model(o, u, l, xa, xb, xc, xd);
    cyc = 0;
    while ((busy || done) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    op = o; unsigned_op = u; long_op = l;
    a = xa; b = xb; c = xc; d = xd;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    check({tag, "_busy1"}, busy, 1'b1);
    check({tag, "_hold"}, {result2, result}, {prev_r2, prev_r});
    while (!done && cyc < 40) begin
      if (noise) begin
        start = 1'($urandom);
        a = $urandom; b = $urandom; c = $urandom; d = $urandom;
        op = 2'($urandom); unsigned_op = 1'($urandom); long_op = 1'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({tag, "_lat"}, cyc, e.lat);
    check({tag, "_busy_at_done"}, busy, 1'b0);
    check({tag, "_res"}, result, e.r);
    check({tag, "_res2"}, result2, e.r2);
    check({tag, "_dbz"}, div_by_zero, e.dbz);
    prev_r = e.r; prev_r2 = e.r2; prev_dbz = e.dbz;
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] specials [6];
    specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
    if ($urandom_range(3) == 0) return specials[$urandom_range(5)];
    return $urandom;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc;
    exp_t e;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_res", result, 32'h0);
    check("rst_res2", result2, 32'h0);
    check("rst_dbz", div_by_zero, 1'b0);
    reset = 1'b1;
    @(negedge clk);

    // Directed cases
    run_op("umul_max", 2'b00, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0);
    check("umul_max_lo_const", result, 32'h0000_0001);
    check("umul_max_hi_const", result2, 32'hFFFF_FFFE);
    run_op("smla_long", 2'b01, 1'b0, 1'b1, -32'sd3, 32'd7, 32'h0, 32'h10, 1'b0);
    check("smla_long_const", {result2, result}, 64'hFFFF_FFFF_FFFF_FFFB);
    run_op("sdiv_m7_2", 2'b10, 1'b0, 1'b0, -32'sd7, 32'd2, 0, 0, 1'b0);
`ifdef MD_DIV_EN
    check("sdiv_m7_2_const", {result2, result}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
`endif
    run_op("sdiv_min_m1", 2'b10, 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0);
`ifdef MD_DIV_EN
    check("sdiv_min_m1_const", {div_by_zero, result2, result}, {1'b0, 32'h0, 32'h8000_0000});
`endif
    run_op("div_zero", 2'b10, 1'b1, 1'b0, 32'h1234, 32'h0, 0, 0, 1'b0);
`ifdef MD_DIV_EN
    check("div_zero_const", {div_by_zero, result2, result}, {1'b1, 32'h1234, 32'h0});
`else
    check("div_off_const", {div_by_zero, result2, result}, {1'b1, 32'h0, 32'h0});
`endif
    run_op("rsv_as_mul", 2'b11, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'd5, 0, 0, 1'b0);
    run_op("mla_short", 2'b01, 1'b0, 1'b0, 32'd10, 32'd10, 32'hFFFF_FFFF, 32'h5, 1'b0);

    // Randomized operations with input noise while busy
    for (int i = 0; i < 40; i++) begin
      run_op("rnd", 2'($urandom), 1'($urandom), 1'($urandom), pick(), pick(), pick(), pick(), 1'b1);
    end

    // Start held continuously: accepts every 36 cycles, DONE-cycle start ignored
    e = model(2'b00, 1'b0, 1'b0, 32'd1234, -32'sd77, 0, 0);
    @(negedge clk);
    op = 2'b00; unsigned_op = 1'b0; long_op = 1'b0;
    a = 32'd1234; b = -32'sd77; c = 0; d = 0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc = 1;
    while (!done && cyc < 40) begin @(negedge clk); cyc++; end
    check("cont_first_done", cyc, 35);
    @(negedge clk);
    cyc++;
    while (!done && cyc < 80) begin @(negedge clk); cyc++; end
    start = 1'b0;
    check("cont_second_done", cyc, 71);
    check("cont_res", {result2, result}, {e.r2, e.r});
    prev_r = e.r; prev_r2 = e.r2;

    // Reset in the middle of RUN (iteration 10 = cycle 12 after acceptance)
    @(negedge clk);
    @(negedge clk);
    op = 2'b00; unsigned_op = 1'b1; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    check("mid_busy_pre", busy, 1'b1);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_out", {div_by_zero, result2, result}, 65'h0);
    @(negedge clk);
    reset = 1'b1;
    prev_r = '0; prev_r2 = '0;
    run_op("post_rst_mul", 2'b00, 1'b0, 1'b0, 32'd3, 32'd5, 0, 0, 1'b0);
    check("post_rst_mul_const", result, 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/md_sequencer.md
MD_SEQUENCER -- requirements
Module: md_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request pulse, sampled only in IDLE.
REQ-005 SHALL have port op  input  2  00 MUL, 01 MLA, 10 DIV, 11 reserved (treated as MUL).
REQ-006 SHALL have port unsigned_op  input  1  1 = unsigned, 0 = two's complement.
REQ-007 SHALL have port long_op  input  1  MLA accumulator is {c,d} when 1, {32'h0,c} when 0.
REQ-008 SHALL have ports a, b, c, d  input  32 each  operands; a, b are multiplicands or dividend/divisor.
REQ-009 SHALL have port busy  output  1  high from the cycle after start acceptance until done.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have ports result, result2  output  32 each  low/high product word, or quotient/remainder.
REQ-012 SHALL have port div_by_zero  output  1  sticky flag for the last operation, valid with done.

Function
REQ-013 SHALL latch op, unsigned_op, long_op, a, b, c, d on the clk edge where start=1 in IDLE; start in any other state is ignored.
REQ-014 SHALL use states IDLE -> PREP -> RUN -> FIX -> DONE -> IDLE.
REQ-015 PREP (1 cycle) SHALL form operand magnitudes and the result sign; signed -2^31 is handled as magnitude 2^31 (33-bit internal).
REQ-016 RUN SHALL perform exactly 32 iterations, one per cycle: shift-add for MUL/MLA, restoring shift-subtract for DIV, counted by a 5-bit counter that wraps 31 -> 0 and exits on wrap.
REQ-017 FIX (1 cycle) SHALL apply sign correction and, for MLA, add the accumulator modulo 2^64.
REQ-018 done SHALL assert in DONE, exactly 35 cycles after the start-accept edge; busy SHALL deassert in the same cycle.
REQ-019 MUL SHALL produce {result2,result} = full 64-bit product, signed or unsigned per unsigned_op.
REQ-020 DIV SHALL produce quotient truncated toward zero in result and remainder with the dividend's sign in result2.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL give result=0x80000000, result2=0 with no flag.
REQ-022 DIV with b=0 SHALL skip RUN (PREP -> FIX), give result=0, result2=a, and set div_by_zero; done arrives 3 cycles after acceptance.
REQ-023 result, result2, div_by_zero SHALL update only in FIX and hold until the next operation's FIX.
REQ-024 A start asserted in the DONE cycle SHALL be ignored; a start in the following IDLE cycle SHALL be accepted.

Reset
REQ-025 reset low SHALL force IDLE immediately, abandon any operation, and clear busy, done, result, result2, div_by_zero and the iteration counter to 0.
REQ-026 The first accept after reset release SHALL be the first start sampled high on a clk edge with reset high.

Configuration
REQ-027 Macro MD_DIV_EN SHALL compile in the division datapath (REQ-020..022).
REQ-028 Without MD_DIV_EN, op=10 SHALL go PREP -> FIX, give result=0, result2=0, div_by_zero=1, with done 3 cycles after acceptance; MUL/MLA SHALL be unaffected.

Structure
REQ-029 Package md_pkg SHALL hold the op encodings, state encoding, WIDTH and ITER_CNT_W=5 constants.
REQ-030 One sub-module md_iter_step (combinational single iteration for add or subtract) SHALL be instantiated once in RUN logic.

Verification
REQ-031 Unsigned MUL a=0xFFFFFFFF, b=0xFFFFFFFF -> result=0x00000001, result2=0xFFFFFFFE, done at cycle 35.
REQ-032 Signed MLA long, a=-3, b=7, {c,d}={0x0,0x00000010} -> {result2,result}=0xFFFFFFFF_FFFFFFFB.
REQ-033 Signed DIV a=-7, b=2 -> result=0xFFFFFFFD, result2=0xFFFFFFFF; then 0x80000000 / -1 -> 0x80000000, 0.
REQ-034 DIV b=0, a=0x1234 -> result=0, result2=0x1234, div_by_zero=1, done at cycle 3; without MD_DIV_EN any DIV -> 0, 0, flag=1.
REQ-035 Start held high continuously -> operations accepted every 36 cycles; start pulses while busy have no effect.
REQ-036 reset low at RUN iteration 10 -> busy=0, done=0, outputs 0 same cycle; new MUL 3x5 after release -> result=15.
